inst_fetch_queue: RTL

Instruction fetch queue sitting directly upstream of the Controller. It accepts prefetch requests (`prefetch_PC` / `is_prefetching`), issues one word read at a time to the memory arbiter, and buffers returned instructions with their PCs in a small FIFO. The Controller consumes the FIFO head via `is_issuing`. `flush_pipline` discards everything, including any in-flight read.

---
 rtl/riscv_fetch_pkg.sv | 19 +
 rtl/ifq_fifo.sv | 74 +++++++
 rtl/inst_fetch_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types for the instruction fetch queue
package riscv_fetch_pkg;

  localparam int XLEN = 32;

  // Fetch FSM: DROP waits out a read that was in flight when a flush hit
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } ifq_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - circular buffer of fetched {pc, inst} entries
module ifq_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH_LOG = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,
  input  logic               clear_in,
  input  logic               push_in,
  input  ifq_entry_t         push_entry_in,
  input  logic               pop_in,
  output logic [DEPTH_LOG:0] count_out,
  output ifq_entry_t         head_out
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  ifq_entry_t             mem_q [DEPTH];
  ifq_entry_t             mem_d [DEPTH];
  logic [DEPTH_LOG-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG:0]     count_q, count_d;

  // Next-state: clear wins; otherwise push/pop advance their own pointers
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (en_in) begin
      if (clear_in) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push_in) begin
          mem_d[wr_ptr_q] = push_entry_in;
          wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_in) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_in && !pop_in) begin
          count_d = count_q + 1'b1;
        end else if (!push_in && pop_in) begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // Storage is reset too so the head outputs read as zero out of reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_out = count_q;
  assign head_out  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - prefetch FSM and FIFO front-end for the Controller (option: IFQ_BYPASS_EN)
module inst_fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH_LOG = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush_pipline,
  input  logic [XLEN-1:0] prefetch_PC,
  input  logic            is_prefetching,
  output logic            prefetch_ready,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_PC,
  output logic [XLEN-1:0] inst_data,
  input  logic            is_issuing
);

  localparam logic [DEPTH_LOG:0] DEPTH_V = (DEPTH_LOG + 1)'(1) << DEPTH_LOG;

  ifq_state_t         state_q, state_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [DEPTH_LOG:0] fifo_count;
  logic [DEPTH_LOG:0] occupancy;
  ifq_entry_t         fifo_head;
  ifq_entry_t         push_entry;
  logic               in_flight;
  logic               fifo_valid;
  logic               accept;
  logic               push;
  logic               pop;
  logic               bypass_hit;

  // The outstanding read reserves a slot so a returning word always fits
  assign in_flight      = (state_q == REQ) || (state_q == WAIT);
  assign occupancy      = fifo_count + (DEPTH_LOG + 1)'(in_flight);
  assign prefetch_ready = rdy_in && (state_q == IDLE) && (occupancy < DEPTH_V) && !flush_pipline;
  assign accept         = prefetch_ready && is_prefetching;
  assign fifo_valid     = (fifo_count != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = rdy_in && !flush_pipline && (state_q == WAIT) && mem_resp_valid && !fifo_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed word taken by the Controller in the same cycle is never stored
  assign push = rdy_in && !flush_pipline && (state_q == WAIT) && mem_resp_valid
                && !(bypass_hit && is_issuing);
  assign pop  = rdy_in && !flush_pipline && fifo_valid && is_issuing;

  assign push_entry.pc   = addr_q;
  assign push_entry.inst = mem_resp_data;

  // Next-state: flush first; a read caught by a flush is drained in DROP,
  // unless its response lands in the flush cycle itself, which retires it
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (rdy_in) begin
      if (flush_pipline) begin
        case (state_q)
          WAIT, DROP: state_d = mem_resp_valid ? IDLE : DROP;
          default:    state_d = IDLE;
        endcase
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              state_d = REQ;
              addr_d  = prefetch_PC;
            end
          end
          REQ:  if (mem_req_ready)  state_d = WAIT;
          WAIT: if (mem_resp_valid) state_d = IDLE;
          DROP: if (mem_resp_valid) state_d = IDLE;
        endcase
      end
    end
  end

  // FSM state and the held request address
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = addr_q;

  assign inst_valid = fifo_valid || bypass_hit;
  assign inst_PC    = bypass_hit ? addr_q : fifo_head.pc;
  assign inst_data  = bypass_hit ? mem_resp_data : fifo_head.inst;

  ifq_fifo #(
    .DEPTH_LOG(DEPTH_LOG)
  ) u_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .en_in        (rdy_in),
    .clear_in     (flush_pipline),
    .push_in      (push),
    .push_entry_in(push_entry),
    .pop_in       (pop),
    .count_out    (fifo_count),
    .head_out     (fifo_head)
  );

endmodule
